// File: rtl/uart_rx_mmio_if.sv
// picorv32 native memory bus, as seen between the CPU (master) and a peripheral (slave).
interface uart_rx_mmio_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// UART receiver (8N1) with receive FIFO behind a picorv32 memory-mapped register window.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx_mmio #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [31:0] ADDR_BASE  = 32'h0200_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_mmio_if.slave   bus,
  input  logic            rxd,
  output logic            irq
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push_c, frame_set_c;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d, perr_set_c;
`endif

  logic rxd_meta, rxd_sync, rxd_last;
  logic fall_c;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          empty_c, full_c, pop_c, push_ok_c, ovr_set_c;
  logic          overrun_q, frame_err_q, parity_err_c, irq_en_q;

  logic        sel_c, ack_c, is_rd_c, wr_lo_c;
  logic [1:0]  off_c;
  logic [31:0] rd_c;
  logic        unused_c;

  // Two-flop synchroniser; the extra flop gives the previous synchronised value for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_last <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_last <= rxd_sync;
    end
  end

  assign fall_c = rxd_last && !rxd_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Frame FSM: every sample is taken when the bit-period counter reaches zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d      = perr_q;
    perr_set_c  = 1'b0;
`endif
    if (state_q != S_IDLE && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (fall_c) begin
          state_d = S_START;
          cnt_d   = CNT_W'(DIV / 2 - 1);
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxd_sync) begin
            state_d = S_DATA;
            cnt_d   = CNT_W'(DIV - 1);
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rxd_sync, shreg_q[7:1]};
          cnt_d   = CNT_W'(DIV - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          cnt_d   = CNT_W'(DIV - 1);
          if (^{shreg_q, rxd_sync}) begin
            perr_d     = 1'b1;
            perr_set_c = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (rxd_sync) begin
`ifdef UART_RX_PARITY_EN
            push_c = !perr_q;
`else
            push_c = 1'b1;
`endif
          end else begin
            frame_set_c = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus decode: one-cycle ack, never twice in a row for the same request.
  assign sel_c   = bus.mem_valid && (bus.mem_addr[31:4] == ADDR_BASE[31:4]);
  assign ack_c   = sel_c && !bus.mem_ready;
  assign off_c   = bus.mem_addr[3:2];
  assign is_rd_c = (bus.mem_wstrb == 4'b0000);
  assign wr_lo_c = ack_c && bus.mem_wstrb[0];

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CW'(FIFO_DEPTH));
  assign pop_c     = ack_c && is_rd_c && (off_c == 2'd0) && !empty_c;
  assign push_ok_c = push_c && (!full_c || pop_c);
  assign ovr_set_c = push_c && full_c && !pop_c;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= (parity_err_q && !(wr_lo_c && off_c == 2'd1 && bus.mem_wdata[4])) || perr_set_c;
    end
  end
  assign parity_err_c = parity_err_q;
`else
  assign parity_err_c = 1'b0;
`endif

  always_comb begin
    rd_c = '0;
    case (off_c)
      2'd0: rd_c = empty_c ? 32'd0 : {1'b1, 23'd0, fifo_mem[rptr_q]};
      2'd1: rd_c = {7'd0, 9'(count_q), 11'd0, parity_err_c, frame_err_q, overrun_q, full_c, !empty_c};
      2'd2: rd_c = {31'd0, irq_en_q};
      default: rd_c = '0;
    endcase
  end

  // Storage has no reset; only the pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      fifo_mem[wptr_q] <= shreg_q;
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      irq           <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      overrun_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      irq_en_q      <= 1'b0;
    end else begin
      bus.mem_ready <= ack_c;
      bus.mem_rdata <= (ack_c && is_rd_c) ? rd_c : 32'd0;
      irq           <= irq_en_q && !empty_c;
      if (push_ok_c) wptr_q <= wptr_q + AW'(1);
      if (pop_c)     rptr_q <= rptr_q + AW'(1);
      if (push_ok_c && !pop_c)      count_q <= count_q + CW'(1);
      else if (pop_c && !push_ok_c) count_q <= count_q - CW'(1);
      overrun_q   <= (overrun_q && !(wr_lo_c && off_c == 2'd1 && bus.mem_wdata[2])) || ovr_set_c;
      frame_err_q <= (frame_err_q && !(wr_lo_c && off_c == 2'd1 && bus.mem_wdata[3])) || frame_set_c;
      if (wr_lo_c && off_c == 2'd2) irq_en_q <= bus.mem_wdata[0];
    end
  end

  assign unused_c = ^{bus.mem_addr[1:0], bus.mem_wdata, bus.mem_wstrb};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: serial frame driver, bus driver and a scoreboard monitor.
module tb_uart_rx_mmio;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam logic [31:0] BASE   = 32'h0200_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;
  logic irq;

  uart_rx_mmio_if bus ();

  uart_rx_mmio #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_BASE(BASE), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .rxd(rxd), .irq(irq)
  );

  always #5 clk = ~clk;

  logic        chk_q [$];
  logic [31:0] exp_q [$];
  string       name_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every acknowledge consumes exactly one scoreboard entry.
  logic        mon_chk;
  logic [31:0] mon_exp;
  string       mon_name;
  always @(negedge clk) begin
    if (bus.mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with rdata %h, required no ack", bus.mem_rdata);
      end else begin
        mon_chk  = chk_q.pop_front();
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (mon_chk) check(mon_name, bus.mem_rdata, mon_exp);
      end
    end
  end

  task automatic bus_xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp);
    int lat;
    chk_q.push_back(wstrb == 4'b0000);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.mem_ready !== 1'b1 && lat < 8);
    check({name, "_ack_latency"}, 32'(lat), 32'd1);
    if (bus.mem_ready !== 1'b1) begin
      void'(chk_q.pop_back());
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
  endtask

  task automatic rd(input string name, input logic [3:0] off, input logic [31:0] exp);
    bus_xfer(name, BASE + 32'(off), 32'd0, 4'b0000, exp);
  endtask

  task automatic wr(input string name, input logic [3:0] off, input logic [31:0] data);
    bus_xfer(name, BASE + 32'(off), data, 4'b0001, 32'd0);
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    repeat (DIV) @(negedge clk);
  endtask

  // Sends one frame plus one idle bit; abort_bit in 0..7 pulses reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit);
    @(negedge clk);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        rxd = d[i];
        repeat (DIV / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rxd   = 1'b1;
        return;
      end
      bit_out(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop);
    bit_out(1'b1);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b1, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    repeat (3) @(negedge clk);
    check("reset_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("reset_mem_rdata", bus.mem_rdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    rd("idle_status", 4'h4, 32'h0000_0000);
    rd("idle_data", 4'h0, 32'h0000_0000);
    rd("unmapped_read", 4'hC, 32'h0000_0000);

    // Single byte with interrupt enabled.
    wr("ctrl_wr", 4'h8, 32'h1);
    rd("ctrl_rd", 4'h8, 32'h0000_0001);
    check("irq_before_rx", 32'(irq), 32'd0);
    send(8'hA5);
    check("irq_after_rx", 32'(irq), 32'd1);
    rd("a5_status", 4'h4, 32'h0001_0001);
    rd("a5_data", 4'h0, 32'h8000_00A5);
    rd("a5_data_empty", 4'h0, 32'h0000_0000);
    repeat (2) @(negedge clk);
    check("irq_after_drain", 32'(irq), 32'd0);
    wr("ctrl_off", 4'h8, 32'h0);

    // Overflow: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) send(8'(i));
    rd("full_status", 4'h4, 32'h0010_0007);
    for (int i = 0; i < 16; i++) rd($sformatf("drain_%0d", i), 4'h0, 32'h8000_0000 | 32'(i));
    rd("drained_status", 4'h4, 32'h0000_0004);
    wr("clr_overrun", 4'h4, 32'h4);
    rd("cleared_status", 4'h4, 32'h0000_0000);

    // Framing error followed by a good byte.
    send_frame(8'h3C, 1'b0, -1);
    rd("frame_err_status", 4'h4, 32'h0000_0008);
    send(8'h55);
    rd("after_ferr_status", 4'h4, 32'h0001_0009);
    rd("after_ferr_data", 4'h0, 32'h8000_0055);
    wr("clr_frame", 4'h4, 32'h8);
    rd("frame_cleared", 4'h4, 32'h0000_0000);

    // Short low glitch must be rejected at the start-bit sample.
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    rd("glitch_status", 4'h4, 32'h0000_0000);
    send(8'h81);
    rd("post_glitch_data", 4'h0, 32'h8000_0081);

    // Reset in the middle of data bit 4, with a byte already buffered and irq armed.
    wr("ctrl_on", 4'h8, 32'h1);
    send(8'h11);
    send_frame(8'h7E, 1'b1, 4);
    repeat (3 * DIV) @(negedge clk);
    check("mid_reset_irq", 32'(irq), 32'd0);
    rd("mid_reset_status", 4'h4, 32'h0000_0000);
    rd("mid_reset_ctrl", 4'h8, 32'h0000_0000);
    send(8'h7E);
    rd("after_reset_status", 4'h4, 32'h0001_0001);
    rd("after_reset_data", 4'h0, 32'h8000_007E);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
